// File: rtl/mem_pkg.sv
// Shared constants for the mem_pipe memory: collision-mode encodings and legal read latencies.
package mem_pkg;

  localparam int unsigned READ_FIRST     = 0;
  localparam int unsigned WRITE_FIRST    = 1;
  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 2;

  function automatic bit rd_latency_legal(input int unsigned lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/mem_pipe_lane.sv
// One byte lane of the memory: block-RAM-style storage with an enabled synchronous read register.
module mem_pipe_lane #(
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BYTE_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [BYTE_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [BYTE_WIDTH-1:0] mem [DEPTH];

  // Read register samples the pre-write word on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_pipe.sv
// Pipelined byte-enabled memory with 1- or 2-cycle read latency and selectable collision behaviour.
module mem_pipe
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned COLLISION_MODE = READ_FIRST
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_valid
);

  localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

  if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
    $fatal(1, "mem_pipe: RD_LATENCY must be 1 or 2");
  end
  if ((BYTE_WIDTH == 0) || (DATA_WIDTH == 0) || (DATA_WIDTH % BYTE_WIDTH != 0)) begin : g_bad_width
    $fatal(1, "mem_pipe: DATA_WIDTH must be a non-zero multiple of BYTE_WIDTH");
  end
  if ((COLLISION_MODE != READ_FIRST) && (COLLISION_MODE != WRITE_FIRST)) begin : g_bad_mode
    $fatal(1, "mem_pipe: COLLISION_MODE must be 0 or 1");
  end

  logic                  rd_go;
  logic                  wr_go;
  logic                  fwd_c;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  s1_valid;
  logic [NB-1:0]         s1_fwd;
  logic [DATA_WIDTH-1:0] s1_din;
  logic [DATA_WIDTH-1:0] s1_word;

  assign rd_go = re & ~reset;
  assign wr_go = we & ~reset;
  assign fwd_c = (COLLISION_MODE == WRITE_FIRST) && we && re && (waddr == raddr);

  for (genvar i = 0; i < NB; i++) begin : g_lane
    mem_pipe_lane #(
      .BYTE_WIDTH(BYTE_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_lane (
      .clk  (clk),
      .we   (wr_go & wbe[i]),
      .waddr(waddr),
      .wdata(din[i*BYTE_WIDTH +: BYTE_WIDTH]),
      .re   (rd_go),
      .raddr(raddr),
      .rdata(ram_rdata[i*BYTE_WIDTH +: BYTE_WIDTH])
    );
  end

  // Stage 1: track the issued read and capture write data for write-first forwarding.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_fwd   <= '0;
    end else begin
      s1_valid <= re;
      if (re) begin
        s1_fwd <= fwd_c ? wbe : NB'(0);
        s1_din <= din;
      end
    end
  end

  always_comb begin
    s1_word = ram_rdata;
    for (int i = 0; i < int'(NB); i++) begin
      if (s1_fwd[i]) s1_word[i*BYTE_WIDTH +: BYTE_WIDTH] = s1_din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  if (RD_LATENCY == 1) begin : g_lat1
    logic out_clear;

    // Lane read registers only load on a read, so dout holds between reads; reset masks it to zero.
    always_ff @(posedge clk) begin
      if (reset)   out_clear <= 1'b1;
      else if (re) out_clear <= 1'b0;
    end

    assign dout       = out_clear ? '0 : s1_word;
    assign dout_valid = s1_valid;
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_valid;

    // Stage 2 captures the stage-1 word, isolating it from later writes.
    always_ff @(posedge clk) begin
      if (reset) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_word;
      end
    end

    assign dout       = s2_data;
    assign dout_valid = s2_valid;
  end

endmodule

// File: tb/tb_mem_pipe.sv
// Bench for mem_pipe: four instances (latency 1/2 x read-first/write-first) share one directed stimulus.
module tb_mem_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [NB-1:0] wbe;
  logic [AW-1:0] waddr;
  logic [DW-1:0] din;
  logic          re;
  logic [AW-1:0] raddr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < int'(NB); i++)
      if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int unsigned LAT  = (g / 2) + 1;
    localparam int unsigned MODE = g % 2;

    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [DW-1:0] mm [1 << AW];
    exp_t          q[$];
    int            cyc     = 0;
    bit            rst_q   = 1'b0;
    bit            started = 1'b0;
    logic [DW-1:0] last    = '0;

    mem_pipe #(
      .DATA_WIDTH    (DW),
      .ADDR_WIDTH    (AW),
      .BYTE_WIDTH    (8),
      .RD_LATENCY    (LAT),
      .COLLISION_MODE(MODE)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .wbe       (wbe),
      .waddr     (waddr),
      .din       (din),
      .re        (re),
      .raddr     (raddr),
      .dout      (dout),
      .dout_valid(dout_valid)
    );

    // Reference model: push the expected word when a read is issued, then apply the write.
    initial forever begin
      logic [DW-1:0] w;
      @(posedge clk);
      cyc++;
      rst_q = reset;
      if (reset) begin
        q.delete();
      end else begin
        if (re) begin
          w = mm[raddr];
          if (MODE == 1 && we && waddr == raddr) w = merge(w, din, wbe);
          q.push_back('{data: w, due: cyc + int'(LAT) - 1});
        end
        if (we) mm[waddr] = merge(mm[waddr], din, wbe);
      end
    end

    // Output monitor on the falling edge.
    initial forever begin
      exp_t e;
      @(negedge clk);
      if (rst_q) begin
        started = 1'b1;
        chk($sformatf("g%0d.reset_valid", g), DW'(dout_valid), DW'(0));
        chk($sformatf("g%0d.reset_dout", g), dout, DW'(0));
        last = dout;
      end else if (started) begin
        if (dout_valid) begin
          chk($sformatf("g%0d.valid_expected", g), DW'(q.size() > 0), DW'(1));
          if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("g%0d.data", g), dout, e.data);
            chk($sformatf("g%0d.valid_cycle", g), DW'(cyc), DW'(e.due));
          end
        end else begin
          chk($sformatf("g%0d.dout_hold", g), dout, last);
          if (q.size() > 0 && q[0].due <= cyc) begin
            chk($sformatf("g%0d.valid_missing", g), DW'(dout_valid), DW'(1));
            void'(q.pop_front());
          end
        end
        last = dout;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we  = 1'b0;
    re  = 1'b0;
    wbe = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    we = 1'b1; waddr = a; din = d; wbe = be;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    re = 1'b1; raddr = a;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; re = 1'b0; wbe = '0; waddr = '0; raddr = '0; din = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Preload addresses 0..15 with known words.
    for (int i = 0; i < 16; i++) begin
      idle(); wr(AW'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF); tick();
    end

    // Full write then read next cycle.
    idle(); wr(8'd5, 32'hDEAD_BEEF, 4'hF); tick();
    idle(); rd(8'd5); tick();
    idle(); tick();

    // Partial write of the two low lanes.
    idle(); wr(8'd5, 32'h1122_3344, 4'h3); tick();
    idle(); rd(8'd5); tick();
    idle(); tick();

    // Same-cycle collision on address 9, then a plain read back.
    idle(); wr(8'd9, 32'hAAAA_AAAA, 4'hF); tick();
    idle(); wr(8'd9, 32'h5555_5555, 4'hC); rd(8'd9); tick();
    idle(); rd(8'd9); tick();
    idle(); tick(); tick();

    // Streaming reads 0..15 on consecutive cycles.
    for (int i = 0; i < 16; i++) begin
      idle(); rd(AW'(i)); tick();
    end
    idle(); tick(); tick();

    // Address extremes must not alias.
    idle(); wr(8'd0, 32'h0BAD_F00D, 4'hF); tick();
    idle(); wr(8'd255, 32'hCAFE_F00D, 4'hF); tick();
    idle(); rd(8'd0); tick();
    idle(); rd(8'd255); tick();
    idle(); tick(); tick();

    // Read in flight when reset hits; traffic during reset is ignored.
    idle(); rd(8'd255); tick();
    idle(); reset = 1'b1; tick();
    wr(8'd0, 32'hFFFF_FFFF, 4'hF); rd(8'd0); tick();
    idle(); tick();
    reset = 1'b0; tick(); tick(); tick();

    // Contents retained across reset; first post-reset read has normal latency.
    idle(); rd(8'd255); tick();
    idle(); rd(8'd0); tick();
    idle(); rd(8'd5); tick();
    idle(); repeat (4) tick();

    chk("g0.drained", DW'(g_inst[0].q.size()), DW'(0));
    chk("g1.drained", DW'(g_inst[1].q.size()), DW'(0));
    chk("g2.drained", DW'(g_inst[2].q.size()), DW'(0));
    chk("g3.drained", DW'(g_inst[3].q.size()), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
